// File: rtl/peribus_master.sv
// Peribus initiator: turns single-outstanding CPU load/store requests into
// one-cycle chipselect/strobe pulses and returns a registered ready/err response.
module peribus_master #(
  parameter int NUM_SLOTS      = 4,
  parameter int SLOT_ADDR_BITS = 2,
  parameter int CPU_ADDR_WIDTH = 8,
  parameter int READ_LATENCY   = 1
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      cpu_req,
  input  logic                      cpu_we,
  input  logic [CPU_ADDR_WIDTH-1:0] cpu_addr,
  input  logic [15:0]               cpu_wdata,
  output logic                      cpu_ready,
  output logic                      cpu_err,
  output logic [15:0]               cpu_rdata,
  output logic                      busy,
  output logic [SLOT_ADDR_BITS-1:0] bus_addr,
  output logic [15:0]               bus_write_data,
  output logic                      bus_write_en,
  output logic                      bus_read_en,
  output logic [NUM_SLOTS-1:0]      bus_chipselect,
  input  logic [16*NUM_SLOTS-1:0]   bus_read_data
);

  localparam int SLOT_W = CPU_ADDR_WIDTH - SLOT_ADDR_BITS;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {IDLE, STROBE, WAIT, DONE} state_t;

  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic                      we_q, we_d;
  logic [SLOT_W-1:0]         slot_q, slot_d;
  logic [SLOT_ADDR_BITS-1:0] bus_addr_q, bus_addr_d;
  logic [15:0]               bus_wdata_q, bus_wdata_d;
  logic [NUM_SLOTS-1:0]      cs_q, cs_d;
  logic                      wen_q, wen_d;
  logic                      ren_q, ren_d;
  logic                      ready_q, ready_d;
  logic                      err_q, err_d;
  logic [15:0]               rdata_q, rdata_d;
  logic                      busy_q, busy_d;

  logic [SLOT_W-1:0]         req_slot;
  logic                      req_mapped;
  logic [NUM_SLOTS-1:0]      req_onehot;
  logic [15:0]               rd_mux;

  // Slot decode by equality against every mapped index, so any slot value
  // that matches none of them is unmapped (unsigned by construction).
  always_comb begin
    req_slot   = cpu_addr[CPU_ADDR_WIDTH-1:SLOT_ADDR_BITS];
    req_mapped = 1'b0;
    req_onehot = '0;
    rd_mux     = '0;
    for (int unsigned k = 0; k < NUM_SLOTS; k++) begin
      if (req_slot == SLOT_W'(k)) begin
        req_mapped    = 1'b1;
        req_onehot[k] = 1'b1;
      end
      if (slot_q == SLOT_W'(k)) begin
        rd_mux = bus_read_data[16*k +: 16];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    slot_d      = slot_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    cs_d        = '0;
    wen_d       = 1'b0;
    ren_d       = 1'b0;
    ready_d     = 1'b0;
    err_d       = err_q;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE: begin
        if (cpu_req) begin
          we_d        = cpu_we;
          slot_d      = req_slot;
          bus_addr_d  = cpu_addr[SLOT_ADDR_BITS-1:0];
          bus_wdata_d = cpu_wdata;
          if (req_mapped) begin
            state_d = STROBE;
            cs_d    = req_onehot;
            wen_d   = cpu_we;
            ren_d   = ~cpu_we;
          end else begin
            state_d = DONE;
            ready_d = 1'b1;
            err_d   = 1'b1;
          end
        end
      end
      STROBE: begin
        if (we_q) begin
          state_d = DONE;
          ready_d = 1'b1;
          err_d   = 1'b0;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_W'(READ_LATENCY);
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
          ready_d = 1'b1;
          err_d   = 1'b0;
          rdata_d = rd_mux;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      slot_q      <= '0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      cs_q        <= '0;
      wen_q       <= 1'b0;
      ren_q       <= 1'b0;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
      rdata_q     <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      slot_q      <= slot_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      cs_q        <= cs_d;
      wen_q       <= wen_d;
      ren_q       <= ren_d;
      ready_q     <= ready_d;
      err_q       <= err_d;
      rdata_q     <= rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign cpu_ready      = ready_q;
  assign cpu_err        = err_q;
  assign cpu_rdata      = rdata_q;
  assign busy           = busy_q;
  assign bus_addr       = bus_addr_q;
  assign bus_write_data = bus_wdata_q;
  assign bus_write_en   = wen_q;
  assign bus_read_en    = ren_q;
  assign bus_chipselect = cs_q;

endmodule

// File: tb/tb_peribus_master.sv
// Bench for peribus_master: two instances (read latency 1 and 3), a peripheral
// model on each bus, directed vector table plus randomized transactions.
module tb_peribus_master;

  logic        clock = 1'b0;
  logic        reset_n        [2];
  logic        cpu_req        [2];
  logic        cpu_we         [2];
  logic [7:0]  cpu_addr       [2];
  logic [15:0] cpu_wdata      [2];
  logic        cpu_ready      [2];
  logic        cpu_err        [2];
  logic [15:0] cpu_rdata      [2];
  logic        busy           [2];
  logic [1:0]  bus_addr       [2];
  logic [15:0] bus_write_data [2];
  logic        bus_write_en   [2];
  logic        bus_read_en    [2];
  logic [3:0]  bus_chipselect [2];
  logic [63:0] bus_read_data  [2];

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  peribus_master #(.NUM_SLOTS(4), .SLOT_ADDR_BITS(2), .CPU_ADDR_WIDTH(8), .READ_LATENCY(1)) u_dut0 (
    .clock(clock), .reset_n(reset_n[0]), .cpu_req(cpu_req[0]), .cpu_we(cpu_we[0]),
    .cpu_addr(cpu_addr[0]), .cpu_wdata(cpu_wdata[0]), .cpu_ready(cpu_ready[0]),
    .cpu_err(cpu_err[0]), .cpu_rdata(cpu_rdata[0]), .busy(busy[0]), .bus_addr(bus_addr[0]),
    .bus_write_data(bus_write_data[0]), .bus_write_en(bus_write_en[0]),
    .bus_read_en(bus_read_en[0]), .bus_chipselect(bus_chipselect[0]),
    .bus_read_data(bus_read_data[0]));

  peribus_master #(.NUM_SLOTS(4), .SLOT_ADDR_BITS(2), .CPU_ADDR_WIDTH(8), .READ_LATENCY(3)) u_dut1 (
    .clock(clock), .reset_n(reset_n[1]), .cpu_req(cpu_req[1]), .cpu_we(cpu_we[1]),
    .cpu_addr(cpu_addr[1]), .cpu_wdata(cpu_wdata[1]), .cpu_ready(cpu_ready[1]),
    .cpu_err(cpu_err[1]), .cpu_rdata(cpu_rdata[1]), .busy(busy[1]), .bus_addr(bus_addr[1]),
    .bus_write_data(bus_write_data[1]), .bus_write_en(bus_write_en[1]),
    .bus_read_en(bus_read_en[1]), .bus_chipselect(bus_chipselect[1]),
    .bus_read_data(bus_read_data[1]));

  function automatic int rl(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // Peripheral model: registers written on write strobes; read data is valid
  // only during the single cycle before edge (strobe edge + latency).
  logic [15:0] pmem  [2][16];
  int          pend  [2];
  int          pslot [2];
  int          paddr [2];

  always @(posedge clock) begin
    for (int d = 0; d < 2; d++) begin
      if (!reset_n[d]) begin
        pend[d] = 0;
      end else begin
        for (int k = 0; k < 4; k++) begin
          if (bus_chipselect[d][k] && bus_write_en[d])
            pmem[d][k*4 + int'(bus_addr[d])] = bus_write_data[d];
        end
        if (bus_read_en[d] && bus_chipselect[d] != 4'b0) begin
          pend[d] = rl(d);
          paddr[d] = int'(bus_addr[d]);
          for (int k = 0; k < 4; k++) if (bus_chipselect[d][k]) pslot[d] = k;
        end else if (pend[d] > 0) begin
          pend[d] = pend[d] - 1;
        end
      end
    end
    #1;
    for (int d = 0; d < 2; d++) begin
      for (int k = 0; k < 4; k++) begin
        if (k == pslot[d])
          bus_read_data[d][16*k +: 16] = (pend[d] == 1) ? pmem[d][k*4 + paddr[d]]
                                                        : (pmem[d][k*4 + paddr[d]] ^ 16'h5A5A);
        else
          bus_read_data[d][16*k +: 16] = 16'($urandom);
      end
    end
  end

  // Transaction-level reference state.
  logic [15:0] ref_mem [2][16];
  logic [15:0] last_rd [2];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [63:0] outs(input int d);
    return {21'b0, cpu_ready[d], cpu_err[d], busy[d], bus_write_en[d], bus_read_en[d],
            bus_chipselect[d], bus_addr[d], bus_write_data[d], cpu_rdata[d]};
  endfunction

  // Called just after a negedge with the DUT idle; returns just after the
  // negedge of the idle cycle that follows the DONE cycle.
  task automatic run_txn(input int d, input logic we, input logic [7:0] addr,
                         input logic [15:0] wdata, input logic hold, input int exp_lat,
                         input logic exp_err, input logic [15:0] exp_rdata);
    int         lat;
    int         strobes;
    int         slot;
    logic       mapped;
    logic [3:0] exp_cs;
    string      tag;
    slot    = int'(addr) / 4;
    mapped  = (slot < 4);
    exp_cs  = mapped ? 4'(1 << slot) : 4'b0;
    tag     = $sformatf("d%0d a%02h w%0d", d, addr, we);
    lat     = 0;
    strobes = 0;
    cpu_req[d]   = 1'b1;
    cpu_we[d]    = we;
    cpu_addr[d]  = addr;
    cpu_wdata[d] = wdata;
    @(posedge clock);
    #1;
    cpu_req[d]   = hold;
    cpu_we[d]    = 1'($urandom);
    cpu_addr[d]  = 8'($urandom);
    cpu_wdata[d] = 16'($urandom);
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      if (i == 1) check({tag, " busy"}, 64'(busy[d]), 64'd1);
      check({tag, " rw_excl"}, 64'(bus_write_en[d] & bus_read_en[d]), 64'd0);
      if (bus_chipselect[d] != 4'b0 || bus_write_en[d] || bus_read_en[d]) begin
        strobes++;
        check({tag, " cs"},    64'(bus_chipselect[d]), 64'(exp_cs));
        check({tag, " baddr"}, 64'(bus_addr[d]),       64'(addr[1:0]));
        check({tag, " bwdat"}, 64'(bus_write_data[d]), 64'(wdata));
        check({tag, " wen"},   64'(bus_write_en[d]),   64'(we));
        check({tag, " ren"},   64'(bus_read_en[d]),    64'(!we));
      end
      if (cpu_ready[d]) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) begin
      tests++;
      fails++;
      $display("FAIL %s timeout: got no cpu_ready expected ready within 40 cycles", tag);
    end else begin
      check({tag, " latency"}, 64'(lat),          64'(exp_lat));
      check({tag, " err"},     64'(cpu_err[d]),   64'(exp_err));
      check({tag, " rdata"},   64'(cpu_rdata[d]), 64'(exp_rdata));
    end
    check({tag, " strobes"}, 64'(strobes), mapped ? 64'd1 : 64'd0);
    @(negedge clock);
    check({tag, " ready_pulse"}, 64'(cpu_ready[d]), 64'd0);
    check({tag, " idle"},        64'(busy[d]),      64'd0);
    if (mapped && we)  ref_mem[d][addr[3:0]] = wdata;
    if (mapped && !we) last_rd[d] = ref_mem[d][addr[3:0]];
  endtask

  typedef struct {
    int          d;
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic        hold;
    int          lat;
    logic        err;
    logic [15:0] rdata;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1);
  end

  initial begin
    tbl.push_back('{0, 1'b1, 8'h05, 16'h0010, 1'b0, 2, 1'b0, 16'h0000});
    tbl.push_back('{0, 1'b1, 8'h07, 16'h0002, 1'b0, 2, 1'b0, 16'h0000});
    tbl.push_back('{0, 1'b0, 8'h07, 16'h0000, 1'b0, 3, 1'b0, 16'h0002});
    tbl.push_back('{0, 1'b0, 8'h14, 16'h0000, 1'b0, 1, 1'b1, 16'h0002});
    tbl.push_back('{0, 1'b1, 8'h15, 16'hFFFF, 1'b0, 1, 1'b1, 16'h0002});
    tbl.push_back('{0, 1'b0, 8'h05, 16'h0000, 1'b0, 3, 1'b0, 16'h0010});
    tbl.push_back('{0, 1'b1, 8'h01, 16'hBEEF, 1'b1, 2, 1'b0, 16'h0010});
    tbl.push_back('{0, 1'b1, 8'h0A, 16'h1234, 1'b1, 2, 1'b0, 16'h0010});
    tbl.push_back('{0, 1'b0, 8'h0A, 16'h0000, 1'b1, 3, 1'b0, 16'h1234});
    tbl.push_back('{0, 1'b0, 8'h01, 16'h0000, 1'b0, 3, 1'b0, 16'hBEEF});
    tbl.push_back('{0, 1'b0, 8'hFC, 16'h0000, 1'b0, 1, 1'b1, 16'hBEEF});
    tbl.push_back('{1, 1'b1, 8'h0C, 16'h5A5A, 1'b0, 2, 1'b0, 16'h0000});
    tbl.push_back('{1, 1'b0, 8'h0C, 16'h0000, 1'b0, 5, 1'b0, 16'h5A5A});
    tbl.push_back('{1, 1'b0, 8'h10, 16'h0000, 1'b0, 1, 1'b1, 16'h5A5A});
    tbl.push_back('{1, 1'b0, 8'h0F, 16'h0000, 1'b0, 5, 1'b0, 16'h0000});

    for (int d = 0; d < 2; d++) begin
      reset_n[d] = 1'b0;
      cpu_req[d] = 1'b0;
      cpu_we[d] = 1'b0;
      cpu_addr[d] = 8'h00;
      cpu_wdata[d] = 16'h0000;
      bus_read_data[d] = 64'h0;
      pend[d] = 0;
      pslot[d] = 0;
      paddr[d] = 0;
      last_rd[d] = 16'h0000;
      for (int a = 0; a < 16; a++) begin
        pmem[d][a] = 16'h0000;
        ref_mem[d][a] = 16'h0000;
      end
    end
    #3;
    for (int d = 0; d < 2; d++) check($sformatf("d%0d reset_outs", d), outs(d), 64'd0);
    repeat (2) @(negedge clock);
    reset_n[0] = 1'b1;
    reset_n[1] = 1'b1;
    for (int d = 0; d < 2; d++) check($sformatf("d%0d post_reset_outs", d), outs(d), 64'd0);

    foreach (tbl[i])
      run_txn(tbl[i].d, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].hold,
              tbl[i].lat, tbl[i].err, tbl[i].rdata);

    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 60; i++) begin
        logic [7:0]  a;
        logic        w;
        logic [15:0] wd;
        logic        h;
        logic        m;
        a  = 8'($urandom_range(0, 23));
        w  = 1'($urandom_range(0, 1));
        wd = 16'($urandom);
        h  = (i < 59) ? 1'($urandom_range(0, 1)) : 1'b0;
        m  = (a < 8'd16);
        run_txn(d, w, a, wd, h,
                !m ? 1 : (w ? 2 : 2 + rl(d)),
                !m,
                (m && !w) ? ref_mem[d][a[3:0]] : last_rd[d]);
      end
    end

    // Reset asserted while dut1 waits for read data: everything drops at once.
    cpu_req[1]   = 1'b1;
    cpu_we[1]    = 1'b0;
    cpu_addr[1]  = 8'h0E;
    cpu_wdata[1] = 16'hC3C3;
    @(posedge clock);
    #1 cpu_req[1] = 1'b0;
    @(negedge clock);
    @(negedge clock);
    check("abort in_wait busy", 64'(busy[1]), 64'd1);
    #2 reset_n[1] = 1'b0;
    #1 check("abort async_outs", outs(1), 64'd0);
    repeat (2) begin
      @(negedge clock);
      check("abort held_outs", outs(1), 64'd0);
    end
    reset_n[1] = 1'b1;
    last_rd[1] = 16'h0000;
    repeat (4) begin
      @(negedge clock);
      check("abort no_ready", 64'(cpu_ready[1]), 64'd0);
    end
    run_txn(1, 1'b0, 8'h02, 16'h0000, 1'b0, 5, 1'b0, ref_mem[1][2]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
